tcdm_mux_rr: RTL and testbench
==============================

// Module: tcdm_mux_rr
// PURPOSE
//  N-to-1 TCDM multiplexer: merges NR_INPUTS TCDM initiator ports onto one TCDM target port.
//  Uses round-robin arbitration and in-order response routing via an outstanding-ID FIFO.
//  Counterpart of the 1-to-N TCDM demux in the SoC interconnect.
//  Used where several masters (uDMA, debug, HWPE) share one L2 bank or peripheral port.
// PARAMETERS
//  NR_INPUTS        2  number of initiator ports (>=2)
//  MAX_OUTSTANDING  2  depth of the granted-ID FIFO, i.e. max granted-but-unanswered transactions (>=1)
//  IDX_WIDTH        $clog2(NR_INPUTS)  localparam, width of a port index
// PORTS
//  clk_i           in   1    clock
//  rst_ni          in   1    asynchronous active-low reset
//  test_en_i       in   1    test mode; functionally unused
//  master_ports    -    XBAR_TCDM_BUS_36.Slave [NR_INPUTS]  initiator side (req/add/wen/wdata/be in; gnt/r_valid/r_rdata/r_opc out)
//  slave_port      -    XBAR_TCDM_BUS_36.Master  target side
//  outstanding_o   out  $clog2(MAX_OUTSTANDING+1)  current FIFO fill level
//  resp_err_o      out  1    1-cycle pulse: slave r_valid while FIFO empty
//  conflict_cnt_o  out  32   cycles with >=2 requests pending (see CONFIGURATION)
// BEHAVIOUR
//  Reset: RR pointer=0, FIFO empty, outstanding_o=0, resp_err_o=0, conflict_cnt_o=0.
//   All master gnt/r_valid=0, r_rdata=0, r_opc=0; slave req=0, wen=1, add/wdata/be=0.
//  Arbitration: winner = first requesting port at or after the RR pointer, wrapping from NR_INPUTS-1 to 0.
//   Pointer moves to winner+1 (mod NR_INPUTS) only on a completed handshake (slave req & gnt).
//   Without a handshake, the winner may change between cycles; only the granted beat is committed.
//  Request path: combinational, 0 cycles.
//   slave req = |master req & ~fifo_full.
//   slave add/wen/wdata/be = winner's fields; idle values when no request.
//  Grant: master_ports[winner].gnt = slave gnt & slave req; all other gnt=0.
//   At most one gnt per cycle.
//  FIFO full: slave req=0 and no gnt, even if a pop occurs in the same cycle (conservative).
//  Handshake: push winner index into the FIFO.
//  Response path: combinational, 0 cycles.
//   On slave r_valid with FIFO non-empty: master_ports[head].r_valid/r_rdata/r_opc = slave values.
//   Pop the head in that cycle. Non-selected ports: r_valid=0, r_rdata=0, r_opc=0.
//  Responses are in grant order; the slave must answer in order, >=1 cycle after its gnt.
//  Simultaneous push+pop (FIFO not full): both occur; fill level unchanged.
//   Read/write pointers wrap at MAX_OUTSTANDING.
//  r_valid with FIFO empty: no master sees r_valid, no pop, resp_err_o=1 for that cycle.
//  Writes (wen=0) also produce a response beat and occupy a FIFO slot.
//  rst_ni asserted mid-transaction: all state cleared asynchronously.
//   Outstanding responses are lost; a later r_valid raises resp_err_o.
// CONFIGURATION
//  TCDM_MUX_RR_PERF_CNT_EN defined:
//   conflict_cnt_o increments every cycle in which >=2 master req are high.
//   Saturates at 32'hFFFF_FFFF; reset to 0.
//  Not defined: conflict_cnt_o tied to 32'h0; no counter flops.
// TESTING
//  1. Single port: port0 reads add=0x1C00_0010, slave gnt same cycle, r_valid next cycle with rdata=0xDEAD_BEEF
//     -> port0 gnt in cycle 0, r_valid+rdata in cycle 1; port1 sees nothing.
//  2. Contention, NR_INPUTS=2: both request continuously for 4 cycles with slave always granting
//     -> grants 0,1,0,1; responses routed 0,1,0,1.
//  3. Backpressure: slave gnt=0 for 3 cycles while port1 requests -> no gnt, pointer unchanged, FIFO empty;
//     gnt on cycle 3 -> port1 granted, outstanding_o=1.
//  4. FIFO full, MAX_OUTSTANDING=2: two grants with responses withheld -> slave req=0, outstanding_o=2;
//     one r_valid -> next request forwarded the following cycle.
//  5. Spurious r_valid with FIFO empty -> resp_err_o pulses 1 cycle, all master r_valid=0.
//     Reset asserted with 2 outstanding -> outstanding_o=0 immediately.
//  6. With TCDM_MUX_RR_PERF_CNT_EN: 5 cycles of dual requests -> conflict_cnt_o=5.
//     Without the macro -> conflict_cnt_o stays 0.

Source files
------------

// File: rtl/tcdm_mux_rr.sv
// ---------------------------------------------------------------------------
// tcdm_mux_rr
//   N-to-1 TCDM multiplexer. Merges NR_INPUTS TCDM initiator ports onto one
//   TCDM target port. Uses round-robin arbitration. A FIFO of granted port
//   indices routes the in-order response beats back to their initiators.
//   The request and response paths are both combinational (0 cycles).
//
// Parameters
//   NR_INPUTS        number of initiator ports (>= 2)
//   MAX_OUTSTANDING  depth of the granted-ID FIFO (>= 1)
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   test_en_i        test mode; functionally unused
//   master_*         initiator side, one lane per port:
//                    req/add/wen/wdata/be in, gnt/r_valid/r_rdata/r_opc out
//   slave_*          target side: req/add/wen/wdata/be out,
//                    gnt/r_valid/r_rdata/r_opc in
//   outstanding_o    current FIFO fill level
//   resp_err_o       high for one cycle when slave r_valid arrives while
//                    the FIFO is empty
//   conflict_cnt_o   saturating count of cycles with >= 2 requests pending
//
// Build option
//   TCDM_MUX_RR_PERF_CNT_EN  when defined, the conflict counter is built.
//                            When undefined, conflict_cnt_o is tied to 0.
// ---------------------------------------------------------------------------
module tcdm_mux_rr #(
    parameter int NR_INPUTS       = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   test_en_i,

    input  logic [NR_INPUTS-1:0]                   master_req,
    input  logic [NR_INPUTS-1:0][31:0]             master_add,
    input  logic [NR_INPUTS-1:0]                   master_wen,
    input  logic [NR_INPUTS-1:0][31:0]             master_wdata,
    input  logic [NR_INPUTS-1:0][3:0]              master_be,
    output logic [NR_INPUTS-1:0]                   master_gnt,
    output logic [NR_INPUTS-1:0]                   master_r_valid,
    output logic [NR_INPUTS-1:0][31:0]             master_r_rdata,
    output logic [NR_INPUTS-1:0]                   master_r_opc,

    output logic                                   slave_req,
    output logic [31:0]                            slave_add,
    output logic                                   slave_wen,
    output logic [31:0]                            slave_wdata,
    output logic [3:0]                             slave_be,
    input  logic                                   slave_gnt,
    input  logic                                   slave_r_valid,
    input  logic [31:0]                            slave_r_rdata,
    input  logic                                   slave_r_opc,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   resp_err_o,
    output logic [31:0]                            conflict_cnt_o
);

    localparam int IDX_WIDTH = $clog2(NR_INPUTS);
    localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    // test_en_i has no functional effect; it is kept for port compatibility.
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] fill;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 any_req;
    logic [IDX_WIDTH-1:0] winner;
    logic                 push;
    logic                 pop;
    logic [IDX_WIDTH-1:0] head;

    assign fifo_full  = (fill == CNT_WIDTH'(MAX_OUTSTANDING));
    assign fifo_empty = (fill == '0);
    assign any_req    = |master_req;
    assign head       = fifo_mem[rd_ptr];

    // ------------------------------------------------------------------
    // Round-robin winner: first requester at or after rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        int  idx;
        logic found;
        // NOTE: every variable written in a combinational block gets a
        // default before any branch; a path that leaves one unassigned
        // would infer a latch.
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NR_INPUTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NR_INPUTS) idx = idx - NR_INPUTS;
            if (!found && master_req[idx]) begin
                found  = 1'b1;
                winner = IDX_WIDTH'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request path. A full FIFO blocks the request outright, even when a
    // response pops a slot in the same cycle; this keeps the full check
    // off the response path.
    // ------------------------------------------------------------------
    always_comb begin
        slave_req   = any_req & ~fifo_full;
        slave_add   = '0;
        slave_wen   = 1'b1;
        slave_wdata = '0;
        slave_be    = '0;
        if (slave_req) begin
            slave_add   = master_add[winner];
            slave_wen   = master_wen[winner];
            slave_wdata = master_wdata[winner];
            slave_be    = master_be[winner];
        end
    end

    assign push = slave_req & slave_gnt;

    always_comb begin
        master_gnt = '0;
        if (push) master_gnt[winner] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Response path: the FIFO head names the port that owns this beat.
    // ------------------------------------------------------------------
    assign pop        = slave_r_valid & ~fifo_empty;
    assign resp_err_o = slave_r_valid & fifo_empty;

    always_comb begin
        master_r_valid = '0;
        master_r_rdata = '0;
        master_r_opc   = '0;
        if (pop) begin
            master_r_valid[head] = 1'b1;
            master_r_rdata[head] = slave_r_rdata;
            master_r_opc[head]   = slave_r_opc;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and fill level
    // ------------------------------------------------------------------
    // NOTE: clocked state is updated with non-blocking assignments so that
    // every flop samples the values from before the edge, regardless of the
    // order of the statements.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                rr_ptr <= (winner == IDX_WIDTH'(NR_INPUTS - 1)) ? '0 : winner + 1'b1;
                wr_ptr <= (wr_ptr == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fill <= fill + 1'b1;
            end else if (pop && !push) begin
                fill <= fill - 1'b1;
            end
        end
    end

    // NOTE: the ID storage has no reset. An entry is read only after a push
    // has written it, and the fill level, which is reset, guards every read.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= winner;
    end

    assign outstanding_o = fill;

    // ------------------------------------------------------------------
    // Optional contention counter
    // ------------------------------------------------------------------
`ifdef TCDM_MUX_RR_PERF_CNT_EN
    logic [31:0] conflict_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt <= '0;
        end else if (($countones(master_req) >= 2) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign conflict_cnt_o = conflict_cnt;
`else
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_tcdm_mux_rr
//   Directed bench for tcdm_mux_rr with NR_INPUTS=2 and MAX_OUTSTANDING=2.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_tcdm_mux_rr;

    localparam int N  = 2;
    localparam int MO = 2;

    logic                clk_i     = 1'b0;
    logic                rst_ni    = 1'b0;
    logic                test_en_i = 1'b0;

    logic [N-1:0]        master_req;
    logic [N-1:0][31:0]  master_add;
    logic [N-1:0]        master_wen;
    logic [N-1:0][31:0]  master_wdata;
    logic [N-1:0][3:0]   master_be;
    logic [N-1:0]        master_gnt;
    logic [N-1:0]        master_r_valid;
    logic [N-1:0][31:0]  master_r_rdata;
    logic [N-1:0]        master_r_opc;

    logic                slave_req;
    logic [31:0]         slave_add;
    logic                slave_wen;
    logic [31:0]         slave_wdata;
    logic [3:0]          slave_be;
    logic                slave_gnt;
    logic                slave_r_valid;
    logic [31:0]         slave_r_rdata;
    logic                slave_r_opc;

    logic [$clog2(MO+1)-1:0] outstanding_o;
    logic                resp_err_o;
    logic [31:0]         conflict_cnt_o;

    int total = 0;
    int bad   = 0;

    tcdm_mux_rr #(
        .NR_INPUTS       (N),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .test_en_i      (test_en_i),
        .master_req     (master_req),
        .master_add     (master_add),
        .master_wen     (master_wen),
        .master_wdata   (master_wdata),
        .master_be      (master_be),
        .master_gnt     (master_gnt),
        .master_r_valid (master_r_valid),
        .master_r_rdata (master_r_rdata),
        .master_r_opc   (master_r_opc),
        .slave_req      (slave_req),
        .slave_add      (slave_add),
        .slave_wen      (slave_wen),
        .slave_wdata    (slave_wdata),
        .slave_be       (slave_be),
        .slave_gnt      (slave_gnt),
        .slave_r_valid  (slave_r_valid),
        .slave_r_rdata  (slave_r_rdata),
        .slave_r_opc    (slave_r_opc),
        .outstanding_o  (outstanding_o),
        .resp_err_o     (resp_err_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        master_req    = '0;
        master_add    = '0;
        master_wen    = '1;
        master_wdata  = '0;
        master_be     = '0;
        slave_gnt     = 1'b0;
        slave_r_valid = 1'b0;
        slave_r_rdata = '0;
        slave_r_opc   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected grant / response vectors for two ports requesting back-to-back.
    logic [1:0]  t2_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] t2_add  [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
    logic [1:0]  t2_rv   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_cnt;

    initial begin
        idle();
        rst_ni = 1'b0;

        // ---------------- reset state ----------------
        sample();
        check("rst_outstanding", 32'(outstanding_o), 32'h0);
        check("rst_resp_err",    32'(resp_err_o),    32'h0);
        check("rst_conflict",    conflict_cnt_o,     32'h0);
        check("rst_slave_req",   32'(slave_req),     32'h0);
        check("rst_slave_wen",   32'(slave_wen),     32'h1);
        check("rst_slave_add",   slave_add,          32'h0);
        check("rst_gnt",         32'(master_gnt),    32'h0);
        check("rst_r_valid",     32'(master_r_valid), 32'h0);
        next_cycle();
        rst_ni = 1'b1;

        // ---------------- 1: single port read ----------------
        idle();
        master_req[0] = 1'b1;
        master_add[0] = 32'h1C00_0010;
        master_be[0]  = 4'hF;
        slave_gnt     = 1'b1;
        sample();
        check("t1_slave_req", 32'(slave_req),  32'h1);
        check("t1_slave_add", slave_add,       32'h1C00_0010);
        check("t1_slave_wen", 32'(slave_wen),  32'h1);
        check("t1_slave_be",  32'(slave_be),   32'hF);
        check("t1_gnt",       32'(master_gnt), 32'h1);
        next_cycle();
        idle();
        slave_r_valid = 1'b1;
        slave_r_rdata = 32'hDEAD_BEEF;
        sample();
        check("t1_outstanding", 32'(outstanding_o),    32'h1);
        check("t1_r_valid",     32'(master_r_valid),   32'h1);
        check("t1_rdata0",      master_r_rdata[0],     32'hDEAD_BEEF);
        check("t1_rdata1",      master_r_rdata[1],     32'h0);
        check("t1_resp_err",    32'(resp_err_o),       32'h0);
        next_cycle();
        idle();
        sample();
        check("t1_drained", 32'(outstanding_o), 32'h0);
        next_cycle();

        // ---------------- 2: contention, fresh pointer ----------------
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin
                master_req    = 2'b11;
                master_add[0] = 32'h100;
                master_add[1] = 32'h200;
                slave_gnt     = 1'b1;
            end
            if (k >= 1) begin
                slave_r_valid = 1'b1;
                slave_r_rdata = 32'hA0 + 32'(k);
            end
            sample();
            if (k < 4) begin
                check($sformatf("t2_gnt%0d", k), 32'(master_gnt), 32'(t2_gnt[k]));
                check($sformatf("t2_add%0d", k), slave_add, t2_add[k]);
            end
            if (k >= 1) begin
                check($sformatf("t2_rv%0d", k), 32'(master_r_valid), 32'(t2_rv[k-1]));
                check($sformatf("t2_rdata%0d", k),
                      (t2_rv[k-1] == 2'b01) ? master_r_rdata[0] : master_r_rdata[1],
                      32'hA0 + 32'(k));
            end
            next_cycle();
        end
        idle();
        sample();
        check("t2_drained", 32'(outstanding_o), 32'h0);
        next_cycle();

        // ---------------- 3: backpressure (pointer at 0) ----------------
        for (int k = 0; k < 4; k++) begin
            idle();
            master_req[1] = 1'b1;
            master_add[1] = 32'h300;
            if (k == 2) begin
                master_req[0] = 1'b1;
                master_add[0] = 32'h400;
            end
            slave_gnt = (k == 3);
            sample();
            check($sformatf("t3_out%0d", k), 32'(outstanding_o), 32'h0);
            check($sformatf("t3_gnt%0d", k), 32'(master_gnt), (k == 3) ? 32'h2 : 32'h0);
            check($sformatf("t3_add%0d", k), slave_add, (k == 2) ? 32'h400 : 32'h300);
            next_cycle();
        end
        idle();
        slave_r_valid = 1'b1;
        slave_r_rdata = 32'h33;
        sample();
        check("t3_outstanding", 32'(outstanding_o),  32'h1);
        check("t3_r_valid",     32'(master_r_valid), 32'h2);
        check("t3_rdata1",      master_r_rdata[1],   32'h33);
        next_cycle();

        // ---------------- 4: FIFO full (pointer at 0) ----------------
        idle(); master_req = 2'b01; master_add[0] = 32'h500; slave_gnt = 1'b1;
        sample();
        check("t4a_gnt", 32'(master_gnt), 32'h1);
        next_cycle();
        idle(); master_req = 2'b10; master_add[1] = 32'h600; slave_gnt = 1'b1;
        sample();
        check("t4b_gnt", 32'(master_gnt),    32'h2);
        check("t4b_out", 32'(outstanding_o), 32'h1);
        next_cycle();
        idle(); master_req = 2'b01; master_add[0] = 32'h700; slave_gnt = 1'b1;
        sample();
        check("t4c_out",       32'(outstanding_o), 32'h2);
        check("t4c_slave_req", 32'(slave_req),     32'h0);
        check("t4c_gnt",       32'(master_gnt),    32'h0);
        next_cycle();
        idle(); master_req = 2'b01; master_add[0] = 32'h700; slave_gnt = 1'b1;
        slave_r_valid = 1'b1; slave_r_rdata = 32'h44;
        sample();
        check("t4d_slave_req", 32'(slave_req),      32'h0);
        check("t4d_gnt",       32'(master_gnt),     32'h0);
        check("t4d_r_valid",   32'(master_r_valid), 32'h1);
        check("t4d_rdata0",    master_r_rdata[0],   32'h44);
        next_cycle();
        idle(); master_req = 2'b01; master_add[0] = 32'h700; slave_gnt = 1'b1;
        sample();
        check("t4e_out",       32'(outstanding_o),  32'h1);
        check("t4e_slave_req", 32'(slave_req),      32'h1);
        check("t4e_add",       slave_add,           32'h700);
        check("t4e_gnt",       32'(master_gnt),     32'h1);
        check("t4e_r_valid",   32'(master_r_valid), 32'h0);
        next_cycle();
        idle(); slave_r_valid = 1'b1; slave_r_rdata = 32'h55; slave_r_opc = 1'b1;
        sample();
        check("t4f_out",     32'(outstanding_o),  32'h2);
        check("t4f_r_valid", 32'(master_r_valid), 32'h2);
        check("t4f_rdata1",  master_r_rdata[1],   32'h55);
        check("t4f_opc",     32'(master_r_opc),   32'h2);
        next_cycle();
        idle(); slave_r_valid = 1'b1; slave_r_rdata = 32'h66;
        sample();
        check("t4g_r_valid", 32'(master_r_valid), 32'h1);
        check("t4g_rdata0",  master_r_rdata[0],   32'h66);
        check("t4g_rdata1",  master_r_rdata[1],   32'h0);
        next_cycle();
        idle();
        sample();
        check("t4h_out", 32'(outstanding_o), 32'h0);
        next_cycle();

        // ---------------- 5: spurious response, reset mid-flight ----------------
        idle(); slave_r_valid = 1'b1; slave_r_rdata = 32'h77;
        sample();
        check("t5_resp_err", 32'(resp_err_o),      32'h1);
        check("t5_r_valid",  32'(master_r_valid),  32'h0);
        check("t5_out",      32'(outstanding_o),   32'h0);
        next_cycle();
        idle();
        sample();
        check("t5_resp_err_clr", 32'(resp_err_o), 32'h0);
        next_cycle();
        // Pointer is at 1 after the last grant to port 0 in test 4.
        idle(); master_req = 2'b11; slave_gnt = 1'b1;
        sample();
        check("t5_gnt_a", 32'(master_gnt), 32'h2);
        next_cycle();
        idle(); master_req = 2'b11; slave_gnt = 1'b1;
        sample();
        check("t5_gnt_b", 32'(master_gnt), 32'h1);
        next_cycle();
        idle();
        sample();
        check("t5_out_full", 32'(outstanding_o), 32'h2);
        rst_ni = 1'b0;
        #1;
        check("t5_out_async_rst", 32'(outstanding_o), 32'h0);
        next_cycle();
        rst_ni = 1'b1;
        idle(); slave_r_valid = 1'b1;
        sample();
        check("t5_lost_resp_err", 32'(resp_err_o),     32'h1);
        check("t5_lost_r_valid",  32'(master_r_valid), 32'h0);
        next_cycle();

        // ---------------- 6: conflict counter ----------------
        do_reset();
        idle(); master_req = 2'b01;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            idle(); master_req = 2'b11;
            next_cycle();
        end
        idle();
        sample();
`ifdef TCDM_MUX_RR_PERF_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        check("t6_conflict_cnt", conflict_cnt_o, exp_cnt);
        next_cycle();
        sample();
        check("t6_conflict_hold", conflict_cnt_o, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
